decoder_rr_scheduler: RTL and testbench
=======================================

DECODER_RR_SCHEDULER -- requirements
Module: decoder_rr_scheduler

Interface
REQ-001 Parameter HOLD, default 4, range 1..255: strobe-active cycles per grant.
REQ-002 Parameter SETUP, default 1, range 1..15: select-stable cycles before the strobe asserts.
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 CE  input  1  clock enable; state and counters advance only on edges with CE=1.
REQ-006 REQ  input  16  request lines; bit n requests decoder output n.
REQ-007 SEL  output  4  decoder address {D,C,B,A}; SEL[0]=A.
REQ-008 STROBE_N  output  1  active-low decoder strobe, driving both G1_N and G2_N.
REQ-009 GNT  output  16  one-hot grant; bit n is high from SETUP entry through RECOVER exit for winner n.
REQ-010 BUSY  output  1  high in any state other than IDLE.
REQ-011 DONE  output  1  one-cycle pulse on the edge that leaves RECOVER.

Function
REQ-012 States SHALL be IDLE, SETUP, ACTIVE and RECOVER; all outputs SHALL be registered.
REQ-013 IDLE: if any REQ bit is set, the block SHALL pick a winner by round-robin, latch SEL, set GNT, load the setup counter and go to SETUP.
REQ-014 Round-robin search SHALL start at PTR and run upward, wrapping 15->0; the first set bit wins.
REQ-015 PTR SHALL update to (winner+1) mod 16 on the edge that enters SETUP.
REQ-016 SETUP: STROBE_N=1 and SEL held; after SETUP CE-cycles, STROBE_N SHALL go to 0 and the state SHALL go to ACTIVE with the hold counter loaded to HOLD.
REQ-017 ACTIVE: STROBE_N=0 for exactly HOLD CE-cycles; then STROBE_N=1 and the state SHALL go to RECOVER.
REQ-018 ACTIVE early end: if REQ[winner] is 0 at an edge, STROBE_N SHALL go to 1 and the state SHALL go to RECOVER on that edge, regardless of the remaining count.
REQ-019 RECOVER: lasts one CE-cycle with SEL held and STROBE_N=1; on exit, DONE=1 and GNT=0.
REQ-020 RECOVER exit: the state SHALL go to IDLE; no back-to-back grant in the exit cycle, so there is at least 1 idle cycle between grants.
REQ-021 SEL SHALL change only on the edge entering SETUP, so SEL is never modified while STROBE_N=0.
REQ-022 STROBE_N SHALL never be 0 outside ACTIVE.
REQ-023 REQ changes in SETUP or RECOVER SHALL be ignored; only REQ[winner] is sampled in ACTIVE.
REQ-024 CE=0 SHALL freeze the state, counters and outputs, except DONE, which SHALL be forced to 0.
REQ-025 Counters SHALL be sized to HOLD and SETUP and SHALL not wrap.
REQ-026 HOLD=1 SHALL give exactly one strobe-low cycle.

Reset
REQ-027 RESET=1 at an edge SHALL take priority over CE and all other inputs.
REQ-028 Reset values: state IDLE, PTR=0, SEL=0, STROBE_N=1, GNT=0, BUSY=0, DONE=0, counters=0.
REQ-029 RESET during ACTIVE SHALL force STROBE_N=1 on the same edge, with no DONE pulse.

Verification
REQ-030 Single request: CE=1, HOLD=4, SETUP=1, REQ=0x0020 held -> SEL=5 with GNT=0x0020 one cycle after REQ, STROBE_N=0 for 4 cycles, 1 RECOVER cycle, DONE pulse, then IDLE.
REQ-031 Fairness: REQ=0x8001 held -> grants alternate 0,15,0,15; PTR is 1 after the first grant, and 15 wins next.
REQ-032 Wrap-around: PTR=14, REQ=0x0003 -> winner 0, PTR becomes 1.
REQ-033 Early release: HOLD=10, REQ[3] drops after 2 ACTIVE cycles -> STROBE_N=1 on the next edge, RECOVER, DONE, no further strobe.
REQ-034 Reset mid-ACTIVE: RESET=1 for one edge -> STROBE_N=1, GNT=0, BUSY=0, DONE=0 the next cycle; the first grant after reset starts search at 0.
REQ-035 CE gating: CE toggling 1,0,1,0 -> strobe-low duration equals HOLD CE=1 edges, SEL is stable throughout, and DONE is high only on a CE=1 cycle.

Source files
------------

// File: rtl/decoder_rr_scheduler_if.sv
// Decoder scheduler bus: request/clock-enable inputs and decoder drive outputs.
//   CE       : clock enable from requester side
//   REQ      : 16 request lines, bit n asks for decoder output n
//   SEL      : decoder address {D,C,B,A}
//   STROBE_N : active-low decoder strobe (G1_N/G2_N)
//   GNT      : one-hot grant of the current winner
//   BUSY     : scheduler not idle
//   DONE     : one-cycle end-of-grant pulse
interface decoder_rr_scheduler_if;
  logic        CE;
  logic [15:0] REQ;
  logic [3:0]  SEL;
  logic        STROBE_N;
  logic [15:0] GNT;
  logic        BUSY;
  logic        DONE;

  // Requester / environment side
  modport master (
    output CE, REQ,
    input  SEL, STROBE_N, GNT, BUSY, DONE
  );

  // Scheduler side
  modport slave (
    input  CE, REQ,
    output SEL, STROBE_N, GNT, BUSY, DONE
  );
endinterface

// File: rtl/decoder_rr_scheduler.sv
// Round-robin scheduler driving a 4-to-16 decoder with setup/hold strobe timing.
//   CLK   : system clock, rising edge
//   RESET : synchronous active-high reset, overrides CE
//   bus   : slave side of decoder_rr_scheduler_if (CE, REQ in; SEL, STROBE_N,
//           GNT, BUSY, DONE out, all registered)
module decoder_rr_scheduler #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned SETUP = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  decoder_rr_scheduler_if.slave bus
);

  localparam int unsigned N_REQ   = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned HOLD_W  = $clog2(HOLD + 1);
  localparam int unsigned SETUP_W = $clog2(SETUP + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               strobe_n_q, strobe_n_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic               win_found_c;
  logic [SEL_W-1:0]   win_c;

  // Round-robin pick: scan upward from ptr, wrapping 15->0, first set bit wins
  always_comb begin
    logic [SEL_W-1:0] idx;
    win_found_c = 1'b0;
    win_c       = ptr_q;
    idx         = ptr_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = ptr_q + SEL_W'(i);
      if (!win_found_c && bus.REQ[idx]) begin
        win_found_c = 1'b1;
        win_c       = idx;
      end
    end
  end

  // Next-state and output computation; DONE defaults low so it is a single pulse
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    strobe_n_d  = strobe_n_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    setup_cnt_d = setup_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    if (bus.CE) begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_found_c) begin
            sel_d       = win_c;
            gnt_d       = N_REQ'(1) << win_c;
            ptr_d       = win_c + SEL_W'(1);
            setup_cnt_d = SETUP_W'(SETUP);
            busy_d      = 1'b1;
            strobe_n_d  = 1'b1;
            state_d     = ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Counter saturates: the last setup cycle launches the strobe
          if (setup_cnt_q <= SETUP_W'(1)) begin
            setup_cnt_d = '0;
            hold_cnt_d  = HOLD_W'(HOLD);
            strobe_n_d  = 1'b0;
            state_d     = ST_ACTIVE;
          end else begin
            setup_cnt_d = setup_cnt_q - SETUP_W'(1);
          end
        end
        ST_ACTIVE: begin
          // Dropped request ends the strobe immediately, ahead of the count
          if (!bus.REQ[sel_q] || (hold_cnt_q <= HOLD_W'(1))) begin
            hold_cnt_d = '0;
            strobe_n_d = 1'b1;
            state_d    = ST_RECOVER;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
        ST_RECOVER: begin
          done_d  = 1'b1;
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      strobe_n_q  <= 1'b1;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      setup_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      strobe_n_q  <= strobe_n_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      setup_cnt_q <= setup_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.SEL      = sel_q;
  assign bus.STROBE_N = strobe_n_q;
  assign bus.GNT      = gnt_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Bench for decoder_rr_scheduler: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a grant-timeline reference model.
module tb_decoder_rr_scheduler;

  localparam int unsigned HOLD  = 4;
  localparam int unsigned SETUP = 1;

  logic CLK;
  logic RESET;
  decoder_rr_scheduler_if bus();

  decoder_rr_scheduler #(.HOLD(HOLD), .SETUP(SETUP)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a grant is a timeline of elapsed CE edges since the win
  int m_ptr, m_win, m_el;
  bit m_busy, m_rec, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic ce, input logic [15:0] req);
    bit found;
    if (rst) begin
      m_ptr = 0; m_win = 0; m_el = 0;
      m_busy = 0; m_rec = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!ce) return;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 16; k++) begin
        if (!found && req[(m_ptr + k) % 16]) begin
          found = 1;
          m_win = (m_ptr + k) % 16;
        end
      end
      if (found) begin
        m_ptr  = (m_win + 1) % 16;
        m_busy = 1; m_el = 0; m_rec = 0;
      end
    end else if (m_rec) begin
      m_busy = 0; m_rec = 0; m_done = 1;
    end else if (m_el >= int'(SETUP) && !req[m_win]) begin
      m_rec = 1;
    end else begin
      m_el++;
      if (m_el == int'(SETUP + HOLD)) m_rec = 1;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it
  task automatic cyc(input logic ce, input logic rst, input logic [15:0] req);
    logic [31:0] exp_gnt;
    logic        exp_strobe_n;
    bus.CE  = ce;
    RESET   = rst;
    bus.REQ = req;
    @(posedge CLK);
    model_step(rst, ce, req);
    #1;
    exp_gnt      = m_busy ? (32'(1) << m_win) : 32'(0);
    exp_strobe_n = !(m_busy && !m_rec && (m_el >= int'(SETUP)));
    chk("sel",      32'(bus.SEL),      32'(m_win));
    chk("gnt",      32'(bus.GNT),      exp_gnt);
    chk("strobe_n", 32'(bus.STROBE_N), 32'(exp_strobe_n));
    chk("busy",     32'(bus.BUSY),     32'(m_busy));
    chk("done",     32'(bus.DONE),     32'(m_done));
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 16'h0);
    cyc(1'b0, 1'b1, 16'hFFFF);
  endtask

  // Hold req until DONE is seen, bounded
  task automatic run_until_done(input logic [15:0] req, input int maxc, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      cyc(1'b1, 1'b0, req);
      if (bus.DONE) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  function automatic int idx_of(input logic [15:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    int lo;
    bit seen;
    bit prev_lo;
    bit sel_bad;
    logic [15:0] req;
    logic [15:0] prev_gnt;
    int winners[$];

    // Reset state, with reset overriding CE=0
    do_reset();
    chk("rst_sel",      32'(bus.SEL),      32'd0);
    chk("rst_strobe_n", 32'(bus.STROBE_N), 32'd1);
    chk("rst_gnt",      32'(bus.GNT),      32'd0);
    chk("rst_busy",     32'(bus.BUSY),     32'd0);
    chk("rst_done",     32'(bus.DONE),     32'd0);

    // Single request on output 5
    cyc(1'b1, 1'b0, 16'h0020);
    chk("single_sel", 32'(bus.SEL), 32'd5);
    chk("single_gnt", 32'(bus.GNT), 32'h0020);
    lo = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc(1'b1, 1'b0, 16'h0020);
      if (!bus.STROBE_N) lo++;
      if (bus.DONE) seen = 1;
    end
    chk("single_lo_cycles", 32'(lo), 32'(HOLD));
    chk("single_done",      32'(seen), 32'd1);
    chk("single_idle_busy", 32'(bus.BUSY), 32'd0);
    chk("single_idle_gnt",  32'(bus.GNT), 32'd0);

    // Fairness between outputs 0 and 15
    do_reset();
    prev_gnt = '0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, 16'h8001);
      if (prev_gnt == 16'h0 && bus.GNT != 16'h0) winners.push_back(idx_of(bus.GNT));
      prev_gnt = bus.GNT;
    end
    chk("fair_count", 32'(winners.size() >= 4), 32'd1);
    if (winners.size() >= 4) begin
      chk("fair_w0", 32'(winners[0]), 32'd0);
      chk("fair_w1", 32'(winners[1]), 32'd15);
      chk("fair_w2", 32'(winners[2]), 32'd0);
      chk("fair_w3", 32'(winners[3]), 32'd15);
    end

    // Wrap-around from pointer 14
    do_reset();
    run_until_done(16'h2000, 20, "wrap_first_done");
    cyc(1'b1, 1'b0, 16'h0003);
    chk("wrap_gnt", 32'(bus.GNT), 32'h0001);
    run_until_done(16'h0003, 20, "wrap_second_done");
    cyc(1'b1, 1'b0, 16'h0003);
    chk("wrap_next_gnt", 32'(bus.GNT), 32'h0002);

    // Early release after two strobe-low cycles
    do_reset();
    cyc(1'b1, 1'b0, 16'h0008);
    lo = 0;
    for (int i = 0; i < 10 && lo < 2; i++) begin
      cyc(1'b1, 1'b0, 16'h0008);
      if (!bus.STROBE_N) lo++;
    end
    chk("early_lo_reached", 32'(lo), 32'd2);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("early_strobe_n", 32'(bus.STROBE_N), 32'd1);
    chk("early_recover_busy", 32'(bus.BUSY), 32'd1);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("early_done", 32'(bus.DONE), 32'd1);
    lo = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 16'h0000);
      if (!bus.STROBE_N) lo++;
    end
    chk("early_no_more_strobe", 32'(lo), 32'd0);

    // Reset in the middle of ACTIVE
    do_reset();
    cyc(1'b1, 1'b0, 16'h0100);
    cyc(1'b1, 1'b0, 16'h0100);
    cyc(1'b1, 1'b0, 16'h0100);
    chk("rstact_low", 32'(bus.STROBE_N), 32'd0);
    cyc(1'b1, 1'b1, 16'h0100);
    chk("rstact_strobe_n", 32'(bus.STROBE_N), 32'd1);
    chk("rstact_gnt",      32'(bus.GNT),      32'd0);
    chk("rstact_busy",     32'(bus.BUSY),     32'd0);
    chk("rstact_done",     32'(bus.DONE),     32'd0);
    cyc(1'b1, 1'b0, 16'h8001);
    chk("rstact_first_gnt", 32'(bus.GNT), 32'h0001);

    // CE toggling during a grant
    do_reset();
    cyc(1'b1, 1'b0, 16'h0040);
    lo = 0; seen = 0; sel_bad = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      prev_lo = !bus.STROBE_N;
      cyc(1'(i % 2), 1'b0, 16'h0040);
      if (prev_lo && (i % 2) == 1) lo++;
      if (bus.SEL != 4'd6) sel_bad = 1;
      if (bus.DONE) begin
        seen = 1;
        chk("ce_done_on_ce1", 32'(i % 2), 32'd1);
      end
    end
    chk("ce_lo_edges", 32'(lo), 32'(HOLD));
    chk("ce_sel_stable", 32'(sel_bad), 32'd0);
    chk("ce_done_seen", 32'(seen), 32'd1);
    cyc(1'b0, 1'b0, 16'h0040);
    chk("ce_done_drops", 32'(bus.DONE), 32'd0);

    // Randomized traffic with occasional reset and CE gaps
    req = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = '0;
          1:       req = 16'(1) << $urandom_range(0, 15);
          default: req = 16'($urandom);
        endcase
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0), req);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
